// File: rtl/ret_stack.sv
// ret_stack: return-address stack feeding the next-PC mux; zero-latency top read, saturating pointer, sticky ovf/unf.
module ret_stack #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8,
  parameter int PW    = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic             clr,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             empty,
  output logic             full,
  output logic             ovf,
  output logic             unf
);
  localparam logic [PW:0]   cnt_full = DEPTH[PW:0];
  localparam logic [PW:0]   cnt_one  = 1;
  localparam logic [PW-1:0] ptr_one  = 1;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW:0]      cnt_q, cnt_d;
  logic             ovf_q, ovf_d, unf_q, unf_d;
  logic [PW-1:0]    top, waddr;
  logic             we;
  always_comb begin
    top   = cnt_q[PW-1:0] - ptr_one;
    empty = cnt_q == '0;
    full  = cnt_q == cnt_full;
    q     = empty ? '0 : mem[top];
    ovf   = ovf_q;
    unf   = unf_q;
    // push+pop on a non-empty stack replaces the top; on empty it degrades to a plain push
    we    = !clr && push && (pop || !full);
    waddr = (pop && !empty) ? top : cnt_q[PW-1:0];
    cnt_d = clr ? '0 :
            (push && pop)  ? (empty ? cnt_one : cnt_q) :
            push           ? (full ? cnt_q : cnt_q + cnt_one) :
            pop            ? (empty ? cnt_q : cnt_q - cnt_one) : cnt_q;
    ovf_d = !clr && (ovf_q || (push && !pop && full));
    unf_d = !clr && (unf_q || (pop && !push && empty));
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= d;
  end
endmodule

// File: tb/tb_ret_stack.sv
// tb_ret_stack: directed self-checking bench for ret_stack.
module tb_ret_stack;
  logic       clk = 1'b0;
  logic       reset, push, pop, clr;
  logic [9:0] d;
  logic [9:0] q;
  logic       empty, full, ovf, unf;
  int         n_chk = 0;
  int         n_fail = 0;

  ret_stack #(.WIDTH(10), .DEPTH(8), .PW(3)) dut (
    .clk(clk), .reset(reset), .push(push), .pop(pop), .clr(clr),
    .d(d), .q(q), .empty(empty), .full(full), .ovf(ovf), .unf(unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic op(input logic p, input logic o, input logic c, input logic [9:0] dv);
    @(negedge clk);
    push = p; pop = o; clr = c; d = dv;
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; push = 1'b0; pop = 1'b0; clr = 1'b0; d = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_q", q, 0);
    check("rst_empty", empty, 1);
    check("rst_full", full, 0);
    check("rst_ovf", ovf, 0);
    check("rst_unf", unf, 0);
    @(negedge clk) reset = 1'b0;

    op(1, 0, 0, 10'h001); op(1, 0, 0, 10'h002); op(1, 0, 0, 10'h003);
    check("pre_reset_q", q, 10'h003);
    reset = 1'b1;
    #1;
    check("mid_rst_q", q, 0);
    check("mid_rst_empty", empty, 1);
    check("mid_rst_full", full, 0);
    check("mid_rst_ovf", ovf, 0);
    check("mid_rst_unf", unf, 0);
    @(negedge clk) reset = 1'b0;
    op(1, 0, 0, 10'h005);
    check("post_rst_push_q", q, 10'h005);
    check("post_rst_empty", empty, 0);
    op(0, 0, 1, 10'h000);
    check("clr_empty", empty, 1);

    op(1, 0, 0, 10'h010); op(1, 0, 0, 10'h020); op(1, 0, 0, 10'h030);
    check("push3_q", q, 10'h030);
    op(0, 1, 0, 0); check("pop1_q", q, 10'h020);
    op(0, 1, 0, 0); check("pop2_q", q, 10'h010);
    op(0, 1, 0, 0); check("pop3_q", q, 0);
    check("pop3_empty", empty, 1);
    check("pop3_unf", unf, 0);

    for (int i = 0; i < 8; i++) begin
      op(1, 0, 0, 10'h100 + 10'(i));
      if (i == 6) check("fill7_full", full, 0);
    end
    check("fill_full", full, 1);
    check("fill_q", q, 10'h107);
    check("fill_ovf", ovf, 0);
    op(1, 0, 0, 10'h3FF);
    check("ovf_set", ovf, 1);
    check("ovf_q", q, 10'h107);
    check("ovf_full", full, 1);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("drain_q%0d", i), q, 10'h107 - 10'(i));
      op(0, 1, 0, 0);
    end
    check("drain_empty", empty, 1);
    check("drain_ovf_sticky", ovf, 1);

    op(0, 1, 0, 0);
    check("unf_set", unf, 1);
    check("unf_empty", empty, 1);
    op(1, 0, 0, 10'h001);
    check("unf_push_q", q, 10'h001);
    check("unf_sticky", unf, 1);
    op(0, 0, 1, 0);
    check("clr2_empty", empty, 1);
    check("clr2_unf", unf, 0);
    check("clr2_ovf", ovf, 0);

    op(1, 0, 0, 10'h040); op(1, 0, 0, 10'h050);
    op(1, 1, 0, 10'h060);
    check("repl_q", q, 10'h060);
    op(0, 1, 0, 0);
    check("repl_pop_q", q, 10'h040);
    op(0, 1, 0, 0);
    check("repl_drain_empty", empty, 1);

    op(1, 1, 0, 10'h2AA);
    check("pp_empty_q", q, 10'h2AA);
    check("pp_empty_empty", empty, 0);
    check("pp_empty_unf", unf, 0);
    op(0, 1, 0, 0);
    check("pp_empty_pop", empty, 1);
    op(1, 0, 1, 10'h123);
    check("clr_push_empty", empty, 1);
    check("clr_push_q", q, 0);

    for (int i = 0; i < 8; i++) op(1, 0, 0, 10'h200 + 10'(i));
    op(1, 1, 0, 10'h0AB);
    check("repl_full_q", q, 10'h0AB);
    check("repl_full_full", full, 1);
    check("repl_full_ovf", ovf, 0);
    op(0, 1, 0, 0);
    check("repl_full_pop_q", q, 10'h206);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
